// File: rtl/mavg_pkg.sv
`default_nettype none
// ============================================================================
// mavg_pkg : shared widths and types for the moving-average datapath
// Rev 1.0
// ============================================================================
package mavg_pkg;

    localparam int MAVG_W     = 4;
    localparam int MAVG_LOG2N = 2;
    localparam int MAVG_SUM_W = MAVG_W + MAVG_LOG2N;

    typedef logic [MAVG_W-1:0]     sample_t;
    typedef logic [MAVG_SUM_W-1:0] sum_t;

endpackage
`default_nettype wire

// File: rtl/mavg_if.sv
`default_nettype none
// ============================================================================
// mavg_if : sample-in / average-out bus between the pad ring and the core
// Rev 1.0
// ============================================================================
interface mavg_if
    import mavg_pkg::*;
#(
    parameter int W = MAVG_W
);

    logic [W-1:0] x;
    logic [W-1:0] y;

    modport master (output x, input  y);
    modport slave  (input  x, output y);

endinterface
`default_nettype wire

// File: rtl/mavg_window.sv
`default_nettype none
// ============================================================================
// mavg_window : circular buffer of the last N samples, oldest entry exposed
// Rev 1.0
// ============================================================================
module mavg_window
    import mavg_pkg::*;
#(
    parameter int W     = MAVG_W,
    parameter int LOG2N = MAVG_LOG2N
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic [W-1:0] x,
    output logic      [W-1:0] old
);

    localparam int N = 2 ** LOG2N;

    logic [W-1:0]     r_buf [N];
    logic [LOG2N-1:0] r_wp;

    // Entry at the write pointer is the sample about to leave the window.
    assign old = r_buf[r_wp];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                r_buf[i] <= '0;
            end
            r_wp <= '0;
        end else begin
            r_buf[r_wp] <= x;
            r_wp        <= r_wp + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mavg_core.sv
`default_nettype none
// ============================================================================
// mavg_core : running-sum moving average, y = floor(sum of last N samples / N)
// Rev 1.0
// ============================================================================
module mavg_core
    import mavg_pkg::*;
#(
    parameter int W     = MAVG_W,
    parameter int LOG2N = MAVG_LOG2N
) (
    input  wire logic clk,
    input  wire logic reset,
    mavg_if.slave     bus
);

    localparam int SUM_W = W + LOG2N;

    logic [W-1:0]     w_old;
    logic [SUM_W-1:0] w_sum_next;
    logic [SUM_W-1:0] r_sum;
    logic [W-1:0]     r_y;

    mavg_window #(
        .W     (W),
        .LOG2N (LOG2N)
    ) u_window (
        .clk   (clk),
        .reset (reset),
        .x     (bus.x),
        .old   (w_old)
    );

    // r_sum always covers w_old, so the subtraction never goes negative.
    assign w_sum_next = r_sum + SUM_W'(bus.x) - SUM_W'(w_old);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sum <= '0;
            r_y   <= '0;
        end else begin
            r_sum <= w_sum_next;
            r_y   <= w_sum_next[SUM_W-1:LOG2N];
        end
    end

    assign bus.y = r_y;

endmodule
`default_nettype wire
